ahb_resp_mux: RTL and testbench
===============================

Name: ahb_resp_mux

Overview:
- Data-phase stage directly downstream of the AHB address decoder. Consumes the decoder's one-hot hreq and default_slv_sel outputs.
- On each accepted address phase, registers the slave select into the data phase.
- Muxes the selected slave's hrdata/hreadyout/hresp back to the master.
- Contains the built-in default slave, which returns the two-cycle AHB ERROR response for undecoded accesses.

Parameters:
- AHB_DATA_WIDTH, 32, read data width.
- MASTER_X_SLAVE_NUM, 7, number of decoded slaves; must match the decoder's hreq width.

Ports:
- hclk  input  1  bus clock; all state updates on the rising edge.
- hreset  input  1  asynchronous, active-high reset.
- htrans  input  htrans_type (2)  master transfer type: IDLE, BUSY, NONSEQ, SEQ.
- hreq  input  MASTER_X_SLAVE_NUM  one-hot address-phase slave request from the decoder.
- default_slv_sel  input  1  address-phase decode error from the decoder.
- hrdata_slv  input  MASTER_X_SLAVE_NUM x AHB_DATA_WIDTH  per-slave read data.
- hreadyout_slv  input  MASTER_X_SLAVE_NUM  per-slave ready.
- hresp_slv  input  MASTER_X_SLAVE_NUM x 2  per-slave response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- hrdata  output  AHB_DATA_WIDTH  read data to the master.
- hready  output  1  bus ready to the master and to all slaves.
- hresp  output  2  response to the master.
- dp_sel  output  MASTER_X_SLAVE_NUM  registered data-phase one-hot select, for monitors.

Behaviour:
- Address-phase acceptance: an address phase is accepted on any rising hclk where hready=1.
- On acceptance, dp_sel <= hreq and dp_def <= default_slv_sel & ~|hreq.
  - If hreq is multi-hot, only the lowest set index is kept.
  - If default_slv_sel and hreq are both set, the slave wins.
- When hready=0, dp_sel and dp_def hold their values.
- Data-phase mux (combinational from dp_sel, zero added latency):
  - If dp_sel[i]=1: hrdata=hrdata_slv[i], hready=hreadyout_slv[i], hresp=hresp_slv[i].
  - If dp_sel=0 and the default slave FSM is in DS_IDLE: hready=1, hresp=OKAY, hrdata=0. This covers IDLE/BUSY transfers and the cycle after reset.
- Default slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
  - DS_IDLE -> DS_ERR1 when an address phase is accepted with default_slv_sel=1 and hreq=0.
  - DS_ERR1: hready=0, hresp=ERROR, hrdata=0. Unconditionally -> DS_ERR2 next cycle. A master changing htrans to IDLE during DS_ERR1 does not shorten the response.
  - DS_ERR2: hready=1, hresp=ERROR, hrdata=0. The next address phase is accepted in this cycle.
    - Next state DS_ERR1 if the new phase is again undecoded.
    - Otherwise DS_IDLE, with dp_sel loaded from hreq.
- Back-to-back undecoded NONSEQ transfers produce a repeating ERR1, ERR2, ERR1, ERR2 pattern with no OKAY cycle between them.
- Slave RETRY/SPLIT responses pass through unmodified. This block does not track split masters.
- Reset (asynchronous, any cycle including mid-wait-state or mid-ERR1):
  - Immediately: dp_sel=0, dp_def=0, FSM=DS_IDLE.
  - Resulting outputs: hready=1, hresp=OKAY, hrdata=0.
  - Outputs stay at these values until the first accepted transfer after reset release.
- htrans is used only to qualify the optional counter. The decoder already gates hreq and default_slv_sel with htrans.

Optional Feature:
- Macro: AHB_RESP_ERR_CNT_EN.
- When defined, adds two output ports:
  - err_cnt (16 bits): counts every DS_IDLE/DS_ERR2 -> DS_ERR1 transition. Saturates at 16'hFFFF. Reset to 0.
  - err_pulse (1 bit): high for exactly the DS_ERR1 cycle.
- When undefined, neither port exists and there is no counter logic.
- Bus behaviour is identical either way.

Test Plan:
- Reset release, htrans=IDLE, hreq=0 -> hready=1, hresp=00, hrdata=0, dp_sel=0 every cycle.
- NONSEQ with hreq=7'b0000100; slave 2 holds hreadyout low 2 cycles, then returns hrdata=32'hDEAD_BEEF -> dp_sel=0000100 one cycle after acceptance; hready=0,0,1; hrdata=DEAD_BEEF on the hready=1 cycle; next address accepted only then.
- NONSEQ with default_slv_sel=1, hreq=0 -> next cycle hready=0/hresp=01; following cycle hready=1/hresp=01; then hready=1/hresp=00 with htrans=IDLE. With AHB_RESP_ERR_CNT_EN defined: err_cnt=1.
- Two back-to-back undecoded NONSEQ followed by a NONSEQ to slave 0 -> ERR1, ERR2, ERR1, ERR2, then slave 0 data phase; err_cnt=2 when the macro is defined.
- hreset asserted during DS_ERR1 and during a slave wait state -> same-cycle hready=1, hresp=00, dp_sel=0; no ERR2 cycle after release.
- Slave 5 returns hresp=10 (RETRY) for 2 cycles (hready 0, then 1) -> hresp=10 on both cycles, dp_sel=0100000, FSM stays DS_IDLE, err_cnt unchanged.

Source files
------------

// File: rtl/ahb_resp_mux_if.sv
// ----------------------------------------------------------------------------
// ahb_resp_mux_if
// Bundles the address-phase inputs, per-slave data-phase returns and the
// muxed master-facing response of the AHB response mux.
//
//   htrans           master transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hreq             one-hot address-phase slave request from the decoder
//   default_slv_sel  address-phase decode error from the decoder
//   hrdata_slv       per-slave read data
//   hreadyout_slv    per-slave ready
//   hresp_slv        per-slave response (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT)
//   hrdata/hready/hresp  muxed response to the master (hready also to slaves)
//   dp_sel           registered data-phase one-hot select
//
// Modports: 'master' is the bus/stimulus side, 'slave' is the mux itself.
// Handshake: an address phase (hreq/default_slv_sel) is taken on every rising
// hclk where hready=1; while hready=0 the master must hold its address phase.
// ----------------------------------------------------------------------------
interface ahb_resp_mux_if #(
  parameter int AHB_DATA_WIDTH     = 32,
  parameter int MASTER_X_SLAVE_NUM = 7
);
  logic [1:0]                                     htrans;
  logic [MASTER_X_SLAVE_NUM-1:0]                  hreq;
  logic                                           default_slv_sel;
  logic [MASTER_X_SLAVE_NUM-1:0][AHB_DATA_WIDTH-1:0] hrdata_slv;
  logic [MASTER_X_SLAVE_NUM-1:0]                  hreadyout_slv;
  logic [MASTER_X_SLAVE_NUM-1:0][1:0]             hresp_slv;
  logic [AHB_DATA_WIDTH-1:0]                      hrdata;
  logic                                           hready;
  logic [1:0]                                     hresp;
  logic [MASTER_X_SLAVE_NUM-1:0]                  dp_sel;

  modport master (
    output htrans, hreq, default_slv_sel, hrdata_slv, hreadyout_slv, hresp_slv,
    input  hrdata, hready, hresp, dp_sel
  );

  modport slave (
    input  htrans, hreq, default_slv_sel, hrdata_slv, hreadyout_slv, hresp_slv,
    output hrdata, hready, hresp, dp_sel
  );
endinterface

// File: rtl/ahb_resp_mux.sv
// ----------------------------------------------------------------------------
// ahb_resp_mux
// AHB data-phase stage behind the address decoder. Registers the decoded
// slave select on each accepted address phase, muxes the selected slave's
// hrdata/hreadyout/hresp back to the master, and contains the default slave
// that answers undecoded accesses with the two-cycle ERROR response.
//
// Ports:
//   hclk      bus clock, rising edge
//   hreset    asynchronous active-high reset
//   bus       ahb_resp_mux_if.slave (address phase in, response out)
//   ds_state  default-slave FSM state (0 IDLE, 1 ERR1, 2 ERR2) for monitors
//   err_cnt   (AHB_RESP_ERR_CNT_EN only) saturating count of ERR1 entries
//   err_pulse (AHB_RESP_ERR_CNT_EN only) high during the ERR1 cycle
//
// Optional feature macro: AHB_RESP_ERR_CNT_EN adds err_cnt/err_pulse.
// Bus behaviour is identical with or without it.
// ----------------------------------------------------------------------------
module ahb_resp_mux #(
  parameter int AHB_DATA_WIDTH     = 32,
  parameter int MASTER_X_SLAVE_NUM = 7
) (
  input  logic        hclk,
  input  logic        hreset,
  ahb_resp_mux_if.slave bus,
  output logic [1:0]  ds_state
`ifdef AHB_RESP_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt,
  output logic        err_pulse
`endif
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t                     state_q;
  ds_state_t                     state_d;
  logic [MASTER_X_SLAVE_NUM-1:0] dp_sel_q;
  logic                          dp_def_q;
  logic [MASTER_X_SLAVE_NUM-1:0] hreq_low;
  logic                          undecoded;
  logic                          accept;
  logic [AHB_DATA_WIDTH-1:0]     hrdata_c;
  logic                          hready_c;
  logic [1:0]                    hresp_c;

  // Isolate the lowest set bit so a multi-hot request still yields one-hot.
  assign hreq_low  = bus.hreq & (~bus.hreq + MASTER_X_SLAVE_NUM'(1));
  // A decoded slave always beats a simultaneous decode error.
  assign undecoded = bus.default_slv_sel & ~|bus.hreq;
  assign accept    = hready_c;

  // Data-phase select registers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_sel_q <= '0;
      dp_def_q <= 1'b0;
    end else if (accept) begin
      dp_sel_q <= hreq_low;
      dp_def_q <= undecoded;
    end
  end

  // Default slave FSM: state register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  // Default slave FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (accept && undecoded) state_d = DS_ERR1;
      // ERR1 always runs to completion regardless of what the master does.
      DS_ERR1: state_d = DS_ERR2;
      // hready=1 in ERR2, so the next address phase is always taken here.
      DS_ERR2: state_d = undecoded ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // Default slave FSM / data-phase mux: outputs.
  always_comb begin
    hrdata_c = '0;
    hready_c = 1'b1;
    hresp_c  = RESP_OKAY;
    for (int i = 0; i < MASTER_X_SLAVE_NUM; i++) begin
      if (dp_sel_q[i]) begin
        hrdata_c = bus.hrdata_slv[i];
        hready_c = bus.hreadyout_slv[i];
        hresp_c  = bus.hresp_slv[i];
      end
    end
    // dp_def_q is set exactly while the FSM is in ERR1/ERR2.
    if (dp_def_q) begin
      hrdata_c = '0;
      hready_c = (state_q != DS_ERR1);
      hresp_c  = RESP_ERROR;
    end
  end

  assign bus.hrdata = hrdata_c;
  assign bus.hready = hready_c;
  assign bus.hresp  = hresp_c;
  assign bus.dp_sel = dp_sel_q;
  assign ds_state   = state_q;

`ifdef AHB_RESP_ERR_CNT_EN
  logic enter_err1;
  // ERR1 can only be entered from IDLE or ERR2, never re-entered from itself.
  // The decoder only flags errors for NONSEQ/SEQ, so htrans[1] qualifies it.
  assign enter_err1 = (state_d == DS_ERR1) && (state_q != DS_ERR1) && bus.htrans[1];

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      err_cnt <= 16'h0000;
    end else if (enter_err1 && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end
  end

  assign err_pulse = (state_q == DS_ERR1);
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
module tb_ahb_resp_mux;
  localparam int W = 32;
  localparam int N = 7;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR1 = 2'd1;
  localparam logic [1:0] S_ERR2 = 2'd2;

  // Packed observation: {ds_state, hready, hresp, hrdata, dp_sel}
  localparam int OW = 2 + 1 + 2 + W + N;

  typedef struct {
    logic [1:0]    tr;
    logic [N-1:0]  rq;
    logic          df;
    int            idx;
    logic          rdy;
    logic [1:0]    rsp;
    logic [W-1:0]  dat;
    logic [OW-1:0] exp;
  } step_t;

  logic       hclk;
  logic       hreset;
  logic [1:0] ds_state;
`ifdef AHB_RESP_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic        err_pulse;
`endif

  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;

  ahb_resp_mux_if #(.AHB_DATA_WIDTH(W), .MASTER_X_SLAVE_NUM(N)) bus ();

  ahb_resp_mux #(.AHB_DATA_WIDTH(W), .MASTER_X_SLAVE_NUM(N)) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .bus      (bus.slave),
    .ds_state (ds_state)
`ifdef AHB_RESP_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt),
    .err_pulse(err_pulse)
`endif
  );

  // ---------------- clock / reset ----------------
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] tr, input logic [N-1:0] rq, input logic df,
                       input int idx, input logic rdy, input logic [1:0] rsp,
                       input logic [W-1:0] dat);
    bus.htrans          = tr;
    bus.hreq            = rq;
    bus.default_slv_sel = df;
    for (int i = 0; i < N; i++) begin
      bus.hrdata_slv[i]    = 32'hA000_0000 | 32'(i);
      bus.hreadyout_slv[i] = 1'b1;
      bus.hresp_slv[i]     = 2'b00;
    end
    if (idx >= 0) begin
      bus.hrdata_slv[idx]    = dat;
      bus.hreadyout_slv[idx] = rdy;
      bus.hresp_slv[idx]     = rsp;
    end
  endtask

  function automatic step_t mk(input logic [1:0] tr, input logic [N-1:0] rq, input logic df,
                               input int idx, input logic rdy, input logic [1:0] rsp,
                               input logic [W-1:0] dat, input logic [1:0] est,
                               input logic erdy, input logic [1:0] ersp,
                               input logic [W-1:0] edat, input logic [N-1:0] edp);
    step_t s;
    s.tr = tr; s.rq = rq; s.df = df; s.idx = idx; s.rdy = rdy; s.rsp = rsp; s.dat = dat;
    s.exp = {est, erdy, ersp, edat, edp};
    return s;
  endfunction

  function automatic logic [OW-1:0] observe();
    return {ds_state, bus.hready, bus.hresp, bus.hrdata, bus.dp_sel};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [OW-1:0] got, e_v;
    hreset = 1'b1;
    drive(T_IDLE, '0, 1'b0, -1, 1'b1, 2'b00, '0);
    repeat (2) @(negedge hclk);
    exp_q.push_back({S_IDLE, 1'b1, 2'b00, {W{1'b0}}, {N{1'b0}}});
    #2;
    got = observe();
    e_v = exp_q.pop_front();
    n_checks++;
    if (got !== e_v) begin
      n_fail++;
      $display("FAIL reset_held got %h exp %h", got, e_v);
    end
`ifdef AHB_RESP_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 16'd0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err_cnt got %0d/%b exp 0/0", err_cnt, err_pulse);
    end
`endif
    @(negedge hclk);
    hreset = 1'b0;
  endtask

  task automatic test_idle();
    step_t seq[$];
    logic [OW-1:0] got, e_v;
    for (int k = 0; k < 3; k++)
      seq.push_back(mk(T_IDLE, 7'b0, 0, -1, 1, 2'b00, 0, S_IDLE, 1, 2'b00, 0, 7'b0));
    foreach (seq[k]) begin
      @(negedge hclk);
      drive(seq[k].tr, seq[k].rq, seq[k].df, seq[k].idx, seq[k].rdy, seq[k].rsp, seq[k].dat);
      exp_q.push_back(seq[k].exp);
      #2;
      got = observe();
      e_v = exp_q.pop_front();
      n_checks++;
      if (got !== e_v) begin
        n_fail++;
        $display("FAIL idle step %0d got %h exp %h", k, got, e_v);
      end
    end
  endtask

  task automatic test_slave_wait();
    step_t seq[$];
    logic [OW-1:0] got, e_v;
    seq.push_back(mk(T_NONSEQ, 7'b0000100, 0, -1, 1, 2'b00, 0,            S_IDLE, 1, 2'b00, 0,            7'b0000000));
    seq.push_back(mk(T_NONSEQ, 7'b0000001, 0,  2, 0, 2'b00, 32'hDEADBEEF, S_IDLE, 0, 2'b00, 32'hDEADBEEF, 7'b0000100));
    seq.push_back(mk(T_NONSEQ, 7'b0000001, 0,  2, 0, 2'b00, 32'hDEADBEEF, S_IDLE, 0, 2'b00, 32'hDEADBEEF, 7'b0000100));
    seq.push_back(mk(T_NONSEQ, 7'b0000001, 0,  2, 1, 2'b00, 32'hDEADBEEF, S_IDLE, 1, 2'b00, 32'hDEADBEEF, 7'b0000100));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0, -1, 1, 2'b00, 0,            S_IDLE, 1, 2'b00, 32'hA0000000, 7'b0000001));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0, -1, 1, 2'b00, 0,            S_IDLE, 1, 2'b00, 0,            7'b0000000));
    foreach (seq[k]) begin
      @(negedge hclk);
      drive(seq[k].tr, seq[k].rq, seq[k].df, seq[k].idx, seq[k].rdy, seq[k].rsp, seq[k].dat);
      exp_q.push_back(seq[k].exp);
      #2;
      got = observe();
      e_v = exp_q.pop_front();
      n_checks++;
      if (got !== e_v) begin
        n_fail++;
        $display("FAIL slave_wait step %0d got %h exp %h", k, got, e_v);
      end
    end
  endtask

  task automatic test_priority();
    step_t seq[$];
    logic [OW-1:0] got, e_v;
    // Multi-hot plus decode error: lowest slave (2) wins, no error response.
    seq.push_back(mk(T_NONSEQ, 7'b0101100, 1, -1, 1, 2'b00, 0, S_IDLE, 1, 2'b00, 0,            7'b0000000));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0, -1, 1, 2'b00, 0, S_IDLE, 1, 2'b00, 32'hA0000002, 7'b0000100));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0, -1, 1, 2'b00, 0, S_IDLE, 1, 2'b00, 0,            7'b0000000));
    foreach (seq[k]) begin
      @(negedge hclk);
      drive(seq[k].tr, seq[k].rq, seq[k].df, seq[k].idx, seq[k].rdy, seq[k].rsp, seq[k].dat);
      exp_q.push_back(seq[k].exp);
      #2;
      got = observe();
      e_v = exp_q.pop_front();
      n_checks++;
      if (got !== e_v) begin
        n_fail++;
        $display("FAIL priority step %0d got %h exp %h", k, got, e_v);
      end
    end
  endtask

  task automatic test_default_err();
    step_t seq[$];
    logic [OW-1:0] got, e_v;
    seq.push_back(mk(T_NONSEQ, 7'b0, 1, -1, 1, 2'b00, 0, S_IDLE, 1, 2'b00, 0, 7'b0));
    seq.push_back(mk(T_IDLE,   7'b0, 0, -1, 1, 2'b00, 0, S_ERR1, 0, 2'b01, 0, 7'b0));
    seq.push_back(mk(T_IDLE,   7'b0, 0, -1, 1, 2'b00, 0, S_ERR2, 1, 2'b01, 0, 7'b0));
    seq.push_back(mk(T_IDLE,   7'b0, 0, -1, 1, 2'b00, 0, S_IDLE, 1, 2'b00, 0, 7'b0));
    exp_err = exp_err + 1;
    foreach (seq[k]) begin
      @(negedge hclk);
      drive(seq[k].tr, seq[k].rq, seq[k].df, seq[k].idx, seq[k].rdy, seq[k].rsp, seq[k].dat);
      exp_q.push_back(seq[k].exp);
      #2;
      got = observe();
      e_v = exp_q.pop_front();
      n_checks++;
      if (got !== e_v) begin
        n_fail++;
        $display("FAIL default_err step %0d got %h exp %h", k, got, e_v);
      end
    end
`ifdef AHB_RESP_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL default_err_cnt got %0d exp %0d", err_cnt, exp_err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    step_t seq[$];
    logic [OW-1:0] got, e_v;
    seq.push_back(mk(T_NONSEQ, 7'b0000000, 1, -1, 1, 2'b00, 0,            S_IDLE, 1, 2'b00, 0,            7'b0000000));
    seq.push_back(mk(T_NONSEQ, 7'b0000000, 1, -1, 1, 2'b00, 0,            S_ERR1, 0, 2'b01, 0,            7'b0000000));
    seq.push_back(mk(T_NONSEQ, 7'b0000000, 1, -1, 1, 2'b00, 0,            S_ERR2, 1, 2'b01, 0,            7'b0000000));
    seq.push_back(mk(T_NONSEQ, 7'b0000001, 0, -1, 1, 2'b00, 0,            S_ERR1, 0, 2'b01, 0,            7'b0000000));
    seq.push_back(mk(T_NONSEQ, 7'b0000001, 0, -1, 1, 2'b00, 0,            S_ERR2, 1, 2'b01, 0,            7'b0000000));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0,  0, 1, 2'b00, 32'h12345678, S_IDLE, 1, 2'b00, 32'h12345678, 7'b0000001));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0, -1, 1, 2'b00, 0,            S_IDLE, 1, 2'b00, 0,            7'b0000000));
    exp_err = exp_err + 2;
    foreach (seq[k]) begin
      @(negedge hclk);
      drive(seq[k].tr, seq[k].rq, seq[k].df, seq[k].idx, seq[k].rdy, seq[k].rsp, seq[k].dat);
      exp_q.push_back(seq[k].exp);
      #2;
      got = observe();
      e_v = exp_q.pop_front();
      n_checks++;
      if (got !== e_v) begin
        n_fail++;
        $display("FAIL back_to_back step %0d got %h exp %h", k, got, e_v);
      end
    end
`ifdef AHB_RESP_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL back_to_back_cnt got %0d exp %0d", err_cnt, exp_err);
    end
`endif
  endtask

  task automatic test_retry();
    step_t seq[$];
    logic [OW-1:0] got, e_v;
    seq.push_back(mk(T_NONSEQ, 7'b0100000, 0, -1, 1, 2'b00, 0, S_IDLE, 1, 2'b00, 0, 7'b0000000));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0,  5, 0, 2'b10, 0, S_IDLE, 0, 2'b10, 0, 7'b0100000));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0,  5, 1, 2'b10, 0, S_IDLE, 1, 2'b10, 0, 7'b0100000));
    seq.push_back(mk(T_IDLE,   7'b0000000, 0, -1, 1, 2'b00, 0, S_IDLE, 1, 2'b00, 0, 7'b0000000));
    foreach (seq[k]) begin
      @(negedge hclk);
      drive(seq[k].tr, seq[k].rq, seq[k].df, seq[k].idx, seq[k].rdy, seq[k].rsp, seq[k].dat);
      exp_q.push_back(seq[k].exp);
      #2;
      got = observe();
      e_v = exp_q.pop_front();
      n_checks++;
      if (got !== e_v) begin
        n_fail++;
        $display("FAIL retry step %0d got %h exp %h", k, got, e_v);
      end
    end
`ifdef AHB_RESP_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL retry_cnt got %0d exp %0d", err_cnt, exp_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] got, e_v;
    // Reset during ERR1.
    @(negedge hclk);
    drive(T_NONSEQ, 7'b0, 1'b1, -1, 1'b1, 2'b00, '0);
    @(negedge hclk);
    drive(T_IDLE, 7'b0, 1'b0, -1, 1'b1, 2'b00, '0);
    exp_q.push_back({S_ERR1, 1'b0, 2'b01, {W{1'b0}}, {N{1'b0}}});
    #2;
    got = observe(); e_v = exp_q.pop_front(); n_checks++;
    if (got !== e_v) begin n_fail++; $display("FAIL rst_err1_pre got %h exp %h", got, e_v); end
`ifdef AHB_RESP_ERR_CNT_EN
    n_checks++;
    if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b exp 1", err_pulse); end
`endif
    #1 hreset = 1'b1;
    exp_q.push_back({S_IDLE, 1'b1, 2'b00, {W{1'b0}}, {N{1'b0}}});
    #1;
    got = observe(); e_v = exp_q.pop_front(); n_checks++;
    if (got !== e_v) begin n_fail++; $display("FAIL rst_err1_async got %h exp %h", got, e_v); end
    exp_err = 0;
`ifdef AHB_RESP_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 16'd0 || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL rst_err_cnt got %0d/%b exp 0/0", err_cnt, err_pulse);
    end
`endif
    @(negedge hclk);
    hreset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge hclk);
      exp_q.push_back({S_IDLE, 1'b1, 2'b00, {W{1'b0}}, {N{1'b0}}});
      #2;
      got = observe(); e_v = exp_q.pop_front(); n_checks++;
      if (got !== e_v) begin n_fail++; $display("FAIL rst_err1_after step %0d got %h exp %h", k, got, e_v); end
    end
    // Reset during a slave wait state.
    @(negedge hclk);
    drive(T_NONSEQ, 7'b0000100, 1'b0, -1, 1'b1, 2'b00, '0);
    @(negedge hclk);
    drive(T_IDLE, 7'b0, 1'b0, 2, 1'b0, 2'b00, 32'h5555_AAAA);
    exp_q.push_back({S_IDLE, 1'b0, 2'b00, 32'h5555_AAAA, 7'b0000100});
    #2;
    got = observe(); e_v = exp_q.pop_front(); n_checks++;
    if (got !== e_v) begin n_fail++; $display("FAIL rst_wait_pre got %h exp %h", got, e_v); end
    #1 hreset = 1'b1;
    exp_q.push_back({S_IDLE, 1'b1, 2'b00, {W{1'b0}}, {N{1'b0}}});
    #1;
    got = observe(); e_v = exp_q.pop_front(); n_checks++;
    if (got !== e_v) begin n_fail++; $display("FAIL rst_wait_async got %h exp %h", got, e_v); end
    @(negedge hclk);
    hreset = 1'b0;
    drive(T_IDLE, 7'b0, 1'b0, -1, 1'b1, 2'b00, '0);
    exp_q.push_back({S_IDLE, 1'b1, 2'b00, {W{1'b0}}, {N{1'b0}}});
    #2;
    got = observe(); e_v = exp_q.pop_front(); n_checks++;
    if (got !== e_v) begin n_fail++; $display("FAIL rst_wait_after got %h exp %h", got, e_v); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_idle();
    test_slave_wait();
    test_priority();
    test_default_err();
    test_back_to_back();
    test_retry();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
